alu_arbiter: RTL

- Shares the single-cycle ALU between two requesters: the integer pipeline (port 0) and the address/branch helper (port 1).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; operands are registered before the ALU, and the result is registered after it.
- Sits between the requesters and the combinational ALU, driving its ALU_Control/operand_A/operand_B ports and capturing ALU_result/zero.

---
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for the shared single-cycle ALU.
// Operands are registered into the ALU (EXEC) and results registered back per port (RESP).
module alu_arbiter_resp_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  capture,
  input  logic                  consume,
  input  logic [DATA_WIDTH-1:0] result_in,
  input  logic                  zero_in,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero
);
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid  <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
    end else if (capture) begin
      valid  <= 1'b1;
      result <= result_in;
      zero   <= zero_in;
    end else if (consume) begin
      valid  <= 1'b0;
    end
  end
endmodule

module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [CTRL_WIDTH-1:0] req0_ALU_Control,
  input  logic [DATA_WIDTH-1:0] req0_operand_A,
  input  logic [DATA_WIDTH-1:0] req0_operand_B,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [CTRL_WIDTH-1:0] req1_ALU_Control,
  input  logic [DATA_WIDTH-1:0] req1_operand_A,
  input  logic [DATA_WIDTH-1:0] req1_operand_B,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic [DATA_WIDTH-1:0] resp0_result,
  output logic                  resp0_zero,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp1_result,
  output logic                  resp1_zero,
  output logic [CTRL_WIDTH-1:0] alu_ALU_Control,
  output logic [DATA_WIDTH-1:0] alu_operand_A,
  output logic [DATA_WIDTH-1:0] alu_operand_B,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  output logic                  busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef struct packed {
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } alu_req_t;

  logic [1:0]                 state;
  logic                       owner, last_grant, grant;
  logic                       resp_done, can_accept, accept;
  alu_req_t [1:0]             req;
  alu_req_t                   drv;
  logic [1:0]                 req_valid, req_ready, owner_sel;
  logic [1:0]                 resp_valid, resp_ready, resp_zero;
  logic [1:0][DATA_WIDTH-1:0] resp_result;

  assign req[0]     = '{ctrl: req0_ALU_Control, a: req0_operand_A, b: req0_operand_B};
  assign req[1]     = '{ctrl: req1_ALU_Control, a: req1_operand_A, b: req1_operand_B};
  assign req_valid  = {req1_valid, req0_valid};
  assign resp_ready = {resp1_ready, resp0_ready};
  assign owner_sel  = owner ? 2'b10 : 2'b01;

  // Tie goes to the port that did not win last; a lone requester always wins.
  assign grant      = (&req_valid) ? ~last_grant : req_valid[1];
  // Releasing the pending response frees the ALU in the same cycle, so
  // respN_ready feeds straight through to reqM_ready.
  assign resp_done  = (state == RESP) && resp_ready[owner];
  assign can_accept = reset && ((state == IDLE) || resp_done);
  assign req_ready  = {can_accept & req_valid[1] & grant,
                       can_accept & req_valid[0] & ~grant};
  assign accept     = |req_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      drv        <= '0;
    end else begin
      if (accept) begin
        drv        <= req[grant];
        owner      <= grant;
        last_grant <= grant;
      end
      case (state)
        IDLE:    if (accept) state <= EXEC;
        EXEC:    state <= RESP;
        RESP:    if (resp_done) state <= accept ? EXEC : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_slot
    alu_arbiter_resp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clock     (clock),
      .reset     (reset),
      .capture   ((state == EXEC) && owner_sel[g]),
      .consume   (resp_done && owner_sel[g]),
      .result_in (alu_result),
      .zero_in   (alu_zero),
      .valid     (resp_valid[g]),
      .result    (resp_result[g]),
      .zero      (resp_zero[g])
    );
  end

  assign req0_ready      = req_ready[0];
  assign req1_ready      = req_ready[1];
  assign resp0_valid     = resp_valid[0];
  assign resp1_valid     = resp_valid[1];
  assign resp0_result    = resp_result[0];
  assign resp1_result    = resp_result[1];
  assign resp0_zero      = resp_zero[0];
  assign resp1_zero      = resp_zero[1];
  assign alu_ALU_Control = drv.ctrl;
  assign alu_operand_A   = drv.a;
  assign alu_operand_B   = drv.b;
  assign busy            = (state != IDLE);
endmodule
